// File: rtl/spi_master_cfg.sv
// SPI master with configurable frame width, SCLK divider and chip-select count.
// The mode (cpol/cpha), target select and frame are latched when start is
// accepted and stay fixed until the frame completes.
module spi_master_cfg #(
  parameter int FRAME_W  = 24,
  parameter int CLK_DIV  = 2,
  parameter int CS_SEL_W = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [FRAME_W-1:0]    tx_data,
  input  logic [CS_SEL_W-1:0]   cs_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  output logic [FRAME_W-1:0]    rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic [2**CS_SEL_W-1:0] cs_n,
  output logic                  mosi,
  input  logic                  miso
);
  localparam int N_CS   = 2**CS_SEL_W;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2*FRAME_W+1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [FRAME_W-1:0]  tx_sr_q, tx_sr_d;
  logic [FRAME_W-1:0]  rx_sr_q, rx_sr_d;
  logic [FRAME_W-1:0]  rx_data_q, rx_data_d;
  logic [N_CS-1:0]     cs_n_q, cs_n_d;
  logic                busy_q, busy_d, done_q, done_d, sclk_q, sclk_d;
  logic                mosi_q, mosi_d, cpol_q, cpol_d, cpha_q, cpha_d;

  logic                div_last, edge_fire, lead, sample;
  logic [EDGE_W-1:0]   edge_num;

  // Next-state logic: phase sequencing plus the per-SCLK-edge shift/sample action.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;

    div_last  = (div_cnt_q == DIV_W'(CLK_DIV-1));
    // SCLK edges are numbered 1..2*FRAME_W; odd numbers are leading edges.
    // Edge 1 fires on the SETUP->SHIFT transition, the rest inside SHIFT.
    edge_fire = div_last && ((state_q == SETUP) ||
                ((state_q == SHIFT) && (edge_cnt_q != EDGE_W'(2*FRAME_W))));
    edge_num  = edge_cnt_q + EDGE_W'(1);
    lead      = edge_num[0];
    sample    = lead ^ cpha_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETUP;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
          rx_sr_d    = '0;
          busy_d     = 1'b1;
          cs_n_d     = ~(N_CS'(1) << cs_sel);
          sclk_d     = cpol;
          cpol_d     = cpol;
          cpha_d     = cpha;
          // cpha=0 needs the MSB on the wire before the first leading edge;
          // cpha=1 puts it out on that edge instead.
          if (!cpha) begin
            mosi_d  = tx_data[FRAME_W-1];
            tx_sr_d = tx_data << 1;
          end else begin
            mosi_d  = 1'b0;
            tx_sr_d = tx_data;
          end
        end
      end
      SETUP: begin
        if (div_last) begin
          state_d   = SHIFT;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      SHIFT: begin
        if (div_last) begin
          div_cnt_d = '0;
          if (edge_cnt_q == EDGE_W'(2*FRAME_W)) state_d = HOLD;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      HOLD: begin
        if (div_last) begin
          state_d   = IDLE;
          div_cnt_d = '0;
          cs_n_d    = '1;
          rx_data_d = rx_sr_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          mosi_d    = 1'b0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The last trailing edge in cpha=0 has no following bit, so mosi holds.
    if (edge_fire) begin
      sclk_d     = ~sclk_q;
      edge_cnt_d = edge_num;
      if (sample) begin
        rx_sr_d = {rx_sr_q[FRAME_W-2:0], miso};
      end else if (edge_num != EDGE_W'(2*FRAME_W)) begin
        mosi_d  = tx_sr_q[FRAME_W-1];
        tx_sr_d = tx_sr_q << 1;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      cs_n_q     <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sclk    = sclk_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;
endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: default 24-bit/div-2 instance driven with random
// frames and modes against a bit-level slave model, plus an 8-bit/div-1 instance.
module tb_spi_master_cfg;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: FRAME_W=24, CLK_DIV=2
  logic        start_a, sel_a, cpol_a, cpha_a, miso_a;
  logic [23:0] tx_a, rx_a;
  logic        busy_a, done_a, sclk_a, mosi_a;
  logic [1:0]  cs_n_a;
  logic        lb;

  // Instance B: FRAME_W=8, CLK_DIV=1
  logic        start_b, sel_b, cpol_b, cpha_b;
  logic [7:0]  tx_b, rx_b;
  logic        busy_b, done_b, sclk_b, mosi_b;
  logic [1:0]  cs_n_b;

  spi_master_cfg #(.FRAME_W(24), .CLK_DIV(2), .CS_SEL_W(1)) u_a (
    .clk(clk), .resetn(resetn), .start(start_a), .tx_data(tx_a), .cs_sel(sel_a),
    .cpol(cpol_a), .cpha(cpha_a), .rx_data(rx_a), .busy(busy_a), .done(done_a),
    .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a), .miso(miso_a));

  spi_master_cfg #(.FRAME_W(8), .CLK_DIV(1), .CS_SEL_W(1)) u_b (
    .clk(clk), .resetn(resetn), .start(start_b), .tx_data(tx_b), .cs_sel(sel_b),
    .cpol(cpol_b), .cpha(cpha_b), .rx_data(rx_b), .busy(busy_b), .done(done_b),
    .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b), .miso(mosi_b));

  // Behavioural SPI slave for instance A: shifts its word out on the
  // non-sampling SCLK edges and captures mosi on the sampling edges.
  logic        miso_sl = 1'b0;
  logic        sl_act = 1'b0, sl_prev = 1'b0, sl_pol = 1'b0, sl_pha = 1'b0;
  logic [23:0] sl_dat = '0, sl_cap = '0;
  int          sl_idx = 0;
  assign miso_a = lb ? mosi_a : miso_sl;

  always @(posedge clk) begin
    #2;
    if (cs_n_a != 2'b11 && !sl_act) begin
      sl_act = 1'b1; sl_pol = sclk_a; sl_pha = cpha_a;
      sl_idx = 23; sl_cap = '0;
      miso_sl = sl_pha ? 1'b0 : sl_dat[23];
    end else if (sl_act && cs_n_a == 2'b11) begin
      sl_act = 1'b0;
    end else if (sl_act && sclk_a != sl_prev) begin
      if ((sclk_a != sl_pol) == !sl_pha) begin
        sl_cap = {sl_cap[22:0], mosi_a};
      end else if (sl_pha) begin
        if (sl_idx >= 0) miso_sl = sl_dat[sl_idx];
        sl_idx--;
      end else begin
        sl_idx--;
        if (sl_idx >= 0) miso_sl = sl_dat[sl_idx];
      end
    end
    sl_prev = sclk_a;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame on instance A; expectations come from the protocol rules:
  // latency 2*(2*24+2)=100, 24 rising SCLK edges, one fixed select low.
  task automatic xfer_a(input logic [23:0] tx, input logic sel, input logic pol,
                        input logic pha, input logic l, input logic [23:0] sd);
    int cyc, rises, cs_bad, bsy_bad, idle_bad;
    logic prev;
    logic [1:0] ecs;
    logic [23:0] erx;
    ecs = ~(2'b01 << sel);
    erx = l ? tx : sd;
    tx_a = tx; sel_a = sel; cpol_a = pol; cpha_a = pha; lb = l; sl_dat = sd;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("acc_busy", busy_a, 1);
    chk("acc_cs", cs_n_a, ecs);
    chk("acc_sclk", sclk_a, pol);
    prev = sclk_a; cyc = 0; rises = 0; cs_bad = 0; bsy_bad = 0; idle_bad = 0;
    while (cyc < 300) begin
      tick();
      cyc++;
      if (done_a) break;
      if (sclk_a && !prev) rises++;
      prev = sclk_a;
      if (cs_n_a != ecs) cs_bad++;
      if (!busy_a) bsy_bad++;
      if (cyc < 2 && sclk_a != pol) idle_bad++;
    end
    chk("latency", cyc, 100);
    chk("sclk_rises", rises, 24);
    chk("cs_during", cs_bad, 0);
    chk("busy_during", bsy_bad, 0);
    chk("setup_idle", idle_bad, 0);
    chk("rx_data", rx_a, erx);
    chk("end_cs", cs_n_a, 2'b11);
    chk("end_busy", busy_a, 0);
    chk("end_mosi", mosi_a, 0);
    chk("end_sclk", sclk_a, pol);
    if (!l) chk("slave_cap", sl_cap, tx);
    tick();
    chk("done_pulse", done_a, 0);
    chk("rx_hold", rx_a, erx);
  endtask

  // One loopback frame on instance B: latency 1*(2*8+2)=18.
  task automatic xfer_b(input logic [7:0] tx, input logic sel, input logic pol, input logic pha);
    int cyc, rises, cs_bad;
    logic prev;
    logic [1:0] ecs;
    ecs = ~(2'b01 << sel);
    tx_b = tx; sel_b = sel; cpol_b = pol; cpha_b = pha; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    prev = sclk_b; cyc = 0; rises = 0; cs_bad = (cs_n_b != ecs) ? 1 : 0;
    while (cyc < 100) begin
      tick();
      cyc++;
      if (done_b) break;
      if (sclk_b && !prev) rises++;
      prev = sclk_b;
      if (cs_n_b != ecs) cs_bad++;
    end
    chk("b_latency", cyc, 18);
    chk("b_rises", rises, 8);
    chk("b_cs_during", cs_bad, 0);
    chk("b_rx", rx_b, tx);
    chk("b_end_sclk", sclk_b, pol);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, hi, dones;
    logic [23:0] x1, x2;
    resetn = 1'b0; lb = 1'b1;
    start_a = 0; tx_a = '0; sel_a = 0; cpol_a = 1; cpha_a = 1;
    start_b = 0; tx_b = '0; sel_b = 0; cpol_b = 0; cpha_b = 0;
    tick(); tick();
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_sclk", sclk_a, 0);
    chk("rst_mosi", mosi_a, 0);
    chk("rst_cs", cs_n_a, 2'b11);
    chk("rst_rx", rx_a, 0);
    chk("rst_cs_b", cs_n_b, 2'b11);
    resetn = 1'b1;

    // Mode 0 loopback of the reference frame.
    xfer_a(24'hA5C33C, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
    // Modes 1..3 against the slave returning a fixed word.
    xfer_a(24'h3C5AA5, 1'b0, 1'b0, 1'b1, 1'b0, 24'h5A0F81);
    xfer_a(24'hC0FFEE, 1'b1, 1'b1, 1'b0, 1'b0, 24'h5A0F81);
    xfer_a(24'h123456, 1'b0, 1'b1, 1'b1, 1'b0, 24'h5A0F81);

    // Random frames, modes, selects and data sources.
    for (int i = 0; i < 8; i++)
      xfer_a(24'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 24'($urandom));

    // Idle cpol change must not move sclk until the next acceptance.
    xfer_a(24'h0F0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 24'hF0F0F0);
    cpol_a = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("idle_cpol_sclk", sclk_a, 0);
    xfer_a(24'h777777, 1'b1, 1'b1, 1'b0, 1'b0, 24'h888888);

    // Back-to-back with start held high; inputs changed mid-frame are ignored.
    x1 = 24'($urandom); x2 = ~x1;
    lb = 1'b1; tx_a = x1; sel_a = 0; cpol_a = 0; cpha_a = 0; start_a = 1'b1;
    tick();
    cyc = 0;
    while (cyc < 300) begin
      tick();
      cyc++;
      if (cyc == 10) begin tx_a = x2; cpol_a = 1; cpha_a = 1; sel_a = 1; end
      if (done_a) break;
    end
    chk("b2b_latency1", cyc, 100);
    chk("b2b_rx1", rx_a, x1);
    hi = (cs_n_a == 2'b11) ? 1 : 0;
    tick();
    chk("b2b_busy2", busy_a, 1);
    chk("b2b_cs2", cs_n_a, 2'b01);
    chk("b2b_sclk2", sclk_a, 1);
    if (cs_n_a == 2'b11) hi++;
    chk("b2b_cs_gap", hi, 1);
    start_a = 1'b0;
    cyc = 0;
    while (cyc < 300) begin
      tick();
      cyc++;
      if (done_a) break;
    end
    chk("b2b_latency2", cyc, 100);
    chk("b2b_rx2", rx_a, x2);
    tick();

    // Reset abort at cycle 40 of a cpol=1 frame.
    tx_a = 24'h55AA55; sel_a = 1; cpol_a = 1; cpha_a = 0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    resetn = 1'b0;
    tick();
    chk("abort_cs", cs_n_a, 2'b11);
    chk("abort_busy", busy_a, 0);
    chk("abort_sclk", sclk_a, 0);
    chk("abort_rx", rx_a, 0);
    chk("abort_done", done_a, 0);
    resetn = 1'b1;
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done_a) dones++;
    end
    chk("abort_no_done", dones, 0);
    // Start on the very first edge after reset release.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    xfer_a(24'hABCDEF, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0);

    // Small instance: divider 1, 8-bit frames, select 1.
    xfer_b(8'h81, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      xfer_b(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_master_cfg.md
SPI_MASTER_CFG -- requirements
Module: spi_master_cfg

Interface
REQ-001 The block SHALL have a single clock `clk`, with all state updated on its rising edge.
REQ-002 Reset `resetn` SHALL be synchronous and active-low.
REQ-003 Parameter FRAME_W, default 24: bits per transfer, legal range 8..32.
REQ-004 Parameter CLK_DIV, default 2: clk cycles per SCLK half-period, legal value 1 or greater.
REQ-005 Parameter CS_SEL_W, default 1: chip-select index width; N_CS = 2**CS_SEL_W.
REQ-006 Ports, in the form name / direction / width / meaning:
- clk / in / 1 / system clock.
- resetn / in / 1 / synchronous active-low reset.
- start / in / 1 / transfer request, sampled only in IDLE.
- tx_data / in / FRAME_W / frame to send, MSB first.
- cs_sel / in / CS_SEL_W / target slave index.
- cpol / in / 1 / SCLK idle level.
- cpha / in / 1 / 0 = sample on leading edge, 1 = sample on trailing edge.
- rx_data / out / FRAME_W / last received frame.
- busy / out / 1 / high from start acceptance until done.
- done / out / 1 / one-cycle completion pulse.
- sclk / out / 1 / SPI clock.
- cs_n / out / N_CS / active-low selects.
- mosi / out / 1 / serial out.
- miso / in / 1 / serial in.
REQ-007 All outputs SHALL be driven directly from registers.

Function
REQ-008 The state machine SHALL have the states IDLE, SETUP, SHIFT and HOLD.
REQ-009 In IDLE, start=1 SHALL, at that edge:
- latch tx_data, cs_sel, cpol and cpha;
- enter SETUP;
- set busy=1;
- drive cs_n[cs_sel]=0;
- set sclk to the latched cpol.
REQ-010 start SHALL be ignored in every state other than IDLE; the latched configuration SHALL NOT change mid-transfer.
REQ-011 SETUP SHALL last CLK_DIV cycles with sclk at the idle level.
REQ-012 When cpha=0, mosi SHALL present tx_data[FRAME_W-1] from SETUP entry.
REQ-013 SHIFT SHALL last 2*FRAME_W*CLK_DIV cycles, and sclk SHALL toggle every CLK_DIV cycles, producing exactly FRAME_W leading and FRAME_W trailing edges.
REQ-014 For cpha=0:
- miso SHALL be sampled on the same clk edge that creates each leading sclk edge;
- mosi SHALL advance to the next bit on each trailing edge except the last.
REQ-015 For cpha=1:
- mosi SHALL advance on each leading edge, with the first leading edge presenting the MSB;
- miso SHALL be sampled on each trailing edge.
REQ-016 Received bits SHALL shift in MSB first.
REQ-017 HOLD SHALL last CLK_DIV cycles with sclk at the idle level and cs_n still asserted.
REQ-018 On leaving HOLD, at a single edge, the block SHALL:
- deassert all cs_n;
- load rx_data with the shift register;
- set done=1 for exactly one cycle;
- set busy=0;
- set mosi=0;
- enter IDLE.
REQ-019 done SHALL assert exactly CLK_DIV*(2*FRAME_W+2) cycles after the edge at which start was accepted.
REQ-020 rx_data SHALL hold its value between transfers and SHALL update only per REQ-018.
REQ-021 Back-to-back transfers:
- start high during the done cycle SHALL be accepted at the next edge;
- cs_n SHALL therefore stay deasserted for exactly one clk cycle between frames.
REQ-022 Exactly one cs_n bit SHALL be low during a transfer; all cs_n bits SHALL be high in IDLE.
REQ-023 Changes to cpol while idle SHALL NOT affect sclk until the next start is accepted.

Reset
REQ-024 With resetn=0 at a clk edge, the block SHALL, regardless of state:
- go to IDLE;
- set busy=0, done=0, sclk=0, mosi=0;
- set cs_n to all ones;
- set rx_data=0 and clear the latched cpol/cpha.
REQ-025 A reset mid-transfer SHALL abort the transfer with no done pulse.
REQ-026 The block SHALL accept start on the first edge after resetn returns high.

Verification
REQ-027 Defaults, mode 0:
- Stimulus: tx_data=0xA5C33C, miso looped to mosi, start pulse.
- Required response: done at 100 cycles; rx_data=0xA5C33C; exactly 24 sclk rising edges; cs_n[0] low throughout.
REQ-028 Modes 1, 2 and 3:
- Stimulus: a slave model returns 0x5A0F81.
- Required response: rx_data=0x5A0F81 in every mode; sclk idles at cpol; sample and shift edges as specified in REQ-014 and REQ-015.
REQ-029 CLK_DIV=1, FRAME_W=8:
- Stimulus: tx_data=0x81, cs_sel=1.
- Required response: done 18 cycles after acceptance; cs_n=2'b01 during the transfer.
REQ-030 Back-to-back:
- Stimulus: start held high continuously.
- Required response: consecutive frames with cs_n high for exactly one cycle between them; start pulses during busy have no effect.
REQ-031 Reset abort:
- Stimulus: resetn=0 at cycle 40 of a transfer.
- Required response: next cycle shows cs_n all ones, busy=0, sclk=0, rx_data=0, and no done pulse.
REQ-032 Idle cpol change:
- Stimulus: toggle cpol while idle, then start.
- Required response: sclk unchanged until acceptance, then at the new idle level.
